tbus_axi_bridge: RTL and testbench

//  Trinity-bus (tbus) slave that sits directly downstream of the LSU (memblock).
//  It accepts one load/store request at a time and turns it into one AXI4-Lite

---
 rtl/tbus_axi_bridge_pkg.sv | 37 +++
 rtl/tbus_axi_bridge_if.sv | 56 +++++
 rtl/tbus_axi_bridge_mask2strb.sv | 11 +
 rtl/tbus_axi_bridge.sv | 144 ++++++++++++++
 tb/tb_tbus_axi_bridge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tbus_axi_bridge_pkg.sv
// Shared types and constants for the tbus -> AXI4-Lite bridge.
package tbus_axi_bridge_pkg;

  localparam int unsigned TBUS_ADDR_W   = 64;
  localparam int unsigned TBUS_DATA_W   = 64;
  localparam int unsigned TBUS_MASK_W   = 64;
  localparam int unsigned TBUS_LANE_W   = 8;
  localparam int unsigned TBUS_STRB_W   = TBUS_DATA_W / TBUS_LANE_W;
  localparam int unsigned TBUS_OPTYPE_W = 2;
  localparam int unsigned AXI_RESP_W    = 2;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = TBUS_OPTYPE_W'(1);
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = TBUS_OPTYPE_W'(2);
  localparam logic [AXI_RESP_W-1:0]    AXI_RESP_OKAY = AXI_RESP_W'(0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR,
    ST_WR_B,
    ST_RESP
  } bridge_state_e;

  // Request payload latched in the accept cycle
  typedef struct packed {
    logic [TBUS_ADDR_W-1:0] addr;
    logic [TBUS_DATA_W-1:0] wdata;
    logic [TBUS_STRB_W-1:0] wstrb;
  } tbus_req_t;

  function automatic logic [TBUS_ADDR_W-1:0] axi_addr(input logic [TBUS_ADDR_W-1:0] a,
                                                      input logic align);
    return align ? {a[TBUS_ADDR_W-1:3], 3'b000} : a;
  endfunction

endpackage

// File: rtl/tbus_axi_bridge_if.sv
// tbus request/response interface and AXI4-Lite master interface.
interface tbus_if import tbus_axi_bridge_pkg::*; #(
  parameter int unsigned ADDR_W = TBUS_ADDR_W,
  parameter int unsigned DATA_W = TBUS_DATA_W
);
  logic                     tbus_index_valid;
  logic                     tbus_index_ready;
  logic [ADDR_W-1:0]        tbus_index;
  logic [DATA_W-1:0]        tbus_write_data;
  logic [TBUS_MASK_W-1:0]   tbus_write_mask;
  logic [TBUS_OPTYPE_W-1:0] tbus_operation_type;
  logic [DATA_W-1:0]        tbus_read_data;
  logic                     tbus_operation_done;
  logic                     bus_error;

  modport master (
    output tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    input  tbus_index_ready, tbus_read_data, tbus_operation_done, bus_error
  );
  modport slave (
    input  tbus_index_valid, tbus_index, tbus_write_data, tbus_write_mask, tbus_operation_type,
    output tbus_index_ready, tbus_read_data, tbus_operation_done, bus_error
  );
endinterface

interface axi_lite_if import tbus_axi_bridge_pkg::*; #(
  parameter int unsigned ADDR_W = TBUS_ADDR_W,
  parameter int unsigned DATA_W = TBUS_DATA_W
);
  logic [ADDR_W-1:0]      m_araddr;
  logic                   m_arvalid;
  logic                   m_arready;
  logic [DATA_W-1:0]      m_rdata;
  logic [AXI_RESP_W-1:0]  m_rresp;
  logic                   m_rvalid;
  logic                   m_rready;
  logic [ADDR_W-1:0]      m_awaddr;
  logic                   m_awvalid;
  logic                   m_awready;
  logic [DATA_W-1:0]      m_wdata;
  logic [TBUS_STRB_W-1:0] m_wstrb;
  logic                   m_wvalid;
  logic                   m_wready;
  logic [AXI_RESP_W-1:0]  m_bresp;
  logic                   m_bvalid;
  logic                   m_bready;

  modport master (
    output m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    input  m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid
  );
  modport slave (
    input  m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
    output m_arready, m_rdata, m_rresp, m_rvalid, m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/tbus_axi_bridge_mask2strb.sv
// Per-bit write mask to per-byte strobe: a lane is enabled if any of its mask bits is set.
module tbus_mask2strb import tbus_axi_bridge_pkg::*; (
  input  logic [TBUS_MASK_W-1:0] i_mask,
  output logic [TBUS_STRB_W-1:0] o_strb_c
);

  for (genvar g = 0; g < TBUS_STRB_W; g++) begin : g_lane
    assign o_strb_c[g] = |i_mask[TBUS_LANE_W*g +: TBUS_LANE_W];
  end

endmodule

// File: rtl/tbus_axi_bridge.sv
// tbus slave that turns one LSU load/store at a time into one AXI4-Lite transaction.
module tbus_axi_bridge import tbus_axi_bridge_pkg::*; #(
  parameter int unsigned ADDR_W     = TBUS_ADDR_W,
  parameter int unsigned DATA_W     = TBUS_DATA_W,
  parameter bit          ALIGN_ADDR = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  tbus_if.slave      tbus,
  axi_lite_if.master axi
);

  bridge_state_e          r_state, w_state_nxt;
  tbus_req_t              r_req;
  logic [TBUS_STRB_W-1:0] w_strb;
  logic [DATA_W-1:0]      r_rdata, w_rdata_nxt;
  logic                   w_fire;
  logic r_ready, r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready, r_done, r_berr;
  logic w_ready_nxt, w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
  logic w_done_nxt, w_berr_nxt;
  logic r_aw_done, r_w_done, w_aw_done_nxt, w_w_done_nxt;

  tbus_mask2strb u_mask2strb (
    .i_mask   (tbus.tbus_write_mask),
    .o_strb_c (w_strb)
  );

  assign w_fire = tbus.tbus_index_valid & r_ready;

  // Next state, sticky write-channel flags and next registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_rdata_nxt   = r_rdata;
    w_berr_nxt    = 1'b0;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          if (tbus.tbus_operation_type == TBUS_READ) begin
            w_state_nxt = ST_RD_A;
          end else if (tbus.tbus_operation_type == TBUS_WRITE) begin
            w_state_nxt = ST_WR;
          end else begin
            w_state_nxt = ST_RESP;
            w_berr_nxt  = 1'b1;
            w_rdata_nxt = '0;
          end
        end
      end
      ST_RD_A: begin
        if (r_arvalid && axi.m_arready) w_state_nxt = ST_RD_D;
      end
      ST_RD_D: begin
        if (axi.m_rvalid) begin
          w_state_nxt = ST_RESP;
          w_rdata_nxt = DATA_W'(axi.m_rdata);
          w_berr_nxt  = (axi.m_rresp != AXI_RESP_OKAY);
        end
      end
      ST_WR: begin
        w_aw_done_nxt = r_aw_done | (r_awvalid & axi.m_awready);
        w_w_done_nxt  = r_w_done  | (r_wvalid  & axi.m_wready);
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_state_nxt   = ST_WR_B;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      ST_WR_B: begin
        if (axi.m_bvalid) begin
          w_state_nxt = ST_RESP;
          w_berr_nxt  = (axi.m_bresp != AXI_RESP_OKAY);
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt   = (w_state_nxt == ST_IDLE);
    w_arvalid_nxt = (w_state_nxt == ST_RD_A);
    w_rready_nxt  = (w_state_nxt == ST_RD_D);
    w_awvalid_nxt = (w_state_nxt == ST_WR) & ~w_aw_done_nxt;
    w_wvalid_nxt  = (w_state_nxt == ST_WR) & ~w_w_done_nxt;
    w_bready_nxt  = (w_state_nxt == ST_WR_B);
    w_done_nxt    = (w_state_nxt == ST_RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_rdata   <= '0;
      r_ready   <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done    <= 1'b0;
      r_berr    <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ready   <= w_ready_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_done    <= w_done_nxt;
      r_berr    <= w_berr_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  // Request capture; tbus inputs are only sampled in the accept cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_req <= '0;
    end else if (w_fire) begin
      r_req.addr  <= TBUS_ADDR_W'(tbus.tbus_index);
      r_req.wdata <= TBUS_DATA_W'(tbus.tbus_write_data);
      r_req.wstrb <= w_strb;
    end
  end

  assign tbus.tbus_index_ready    = r_ready;
  assign tbus.tbus_read_data      = r_rdata;
  assign tbus.tbus_operation_done = r_done;
  assign tbus.bus_error           = r_berr;

  assign axi.m_araddr  = ADDR_W'(axi_addr(r_req.addr, ALIGN_ADDR));
  assign axi.m_awaddr  = ADDR_W'(axi_addr(r_req.addr, ALIGN_ADDR));
  assign axi.m_wdata   = DATA_W'(r_req.wdata);
  assign axi.m_wstrb   = r_req.wstrb;
  assign axi.m_arvalid = r_arvalid;
  assign axi.m_rready  = r_rready;
  assign axi.m_awvalid = r_awvalid;
  assign axi.m_wvalid  = r_wvalid;
  assign axi.m_bready  = r_bready;

endmodule

// File: tb/tb_tbus_axi_bridge.sv
// Directed self-checking bench for tbus_axi_bridge; the AXI slave is driven step by step.
module tb_tbus_axi_bridge;
  import tbus_axi_bridge_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  tbus_if     u_tbus ();
  axi_lite_if u_axi ();

  tbus_axi_bridge dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tbus    (u_tbus.slave),
    .axi     (u_axi.master)
  );

  localparam logic [63:0] D1 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] D3 = 64'hCAFE_0000_1234_5678;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [63:0] addr,
                     input logic [63:0] data, input logic [63:0] mask);
    u_tbus.tbus_index_valid    = 1'b1;
    u_tbus.tbus_operation_type = op;
    u_tbus.tbus_index          = addr;
    u_tbus.tbus_write_data     = data;
    u_tbus.tbus_write_mask     = mask;
  endtask

  initial begin
    reset_n = 1'b0;
    u_tbus.tbus_index_valid = 1'b0;
    u_tbus.tbus_operation_type = '0;
    u_tbus.tbus_index = '0;
    u_tbus.tbus_write_data = '0;
    u_tbus.tbus_write_mask = '0;
    u_axi.m_arready = 1'b0; u_axi.m_rvalid = 1'b0; u_axi.m_rdata = '0; u_axi.m_rresp = '0;
    u_axi.m_awready = 1'b0; u_axi.m_wready = 1'b0; u_axi.m_bvalid = 1'b0; u_axi.m_bresp = '0;
    step(); step();
    chk("rst_ready", u_tbus.tbus_index_ready, 0);
    chk("rst_done", u_tbus.tbus_operation_done, 0);
    chk("rst_rdata", u_tbus.tbus_read_data, 0);
    chk("rst_valids", {u_axi.m_arvalid, u_axi.m_awvalid, u_axi.m_wvalid}, 0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", u_tbus.tbus_index_ready, 1);

    // 1: zero-wait read
    req(TBUS_READ, 64'h8000_0010, 0, 0);
    u_axi.m_arready = 1'b1;
    step();
    u_tbus.tbus_index_valid = 1'b0;
    chk("t1_ready_low", u_tbus.tbus_index_ready, 0);
    chk("t1_arvalid", u_axi.m_arvalid, 1);
    chk("t1_araddr", u_axi.m_araddr, 64'h8000_0010);
    chk("t1_done_f1", u_tbus.tbus_operation_done, 0);
    step();
    u_axi.m_arready = 1'b0;
    chk("t1_arvalid_drop", u_axi.m_arvalid, 0);
    chk("t1_rready", u_axi.m_rready, 1);
    chk("t1_done_f2", u_tbus.tbus_operation_done, 0);
    u_axi.m_rvalid = 1'b1; u_axi.m_rdata = D1; u_axi.m_rresp = 2'b00;
    step();
    u_axi.m_rvalid = 1'b0;
    chk("t1_done_f3", u_tbus.tbus_operation_done, 1);
    chk("t1_rdata", u_tbus.tbus_read_data, D1);
    chk("t1_berr", u_tbus.bus_error, 0);
    step();
    chk("t1_done_off", u_tbus.tbus_operation_done, 0);
    chk("t1_ready_back", u_tbus.tbus_index_ready, 1);

    // 2: byte store
    req(TBUS_WRITE, 64'h8000_0020, 64'h0000_0000_00AB_0000, 64'h0000_0000_00FF_0000);
    u_axi.m_awready = 1'b1; u_axi.m_wready = 1'b1;
    step();
    u_tbus.tbus_index_valid = 1'b0;
    chk("t2_awvalid", u_axi.m_awvalid, 1);
    chk("t2_wvalid", u_axi.m_wvalid, 1);
    chk("t2_wstrb", u_axi.m_wstrb, 8'b0000_0100);
    chk("t2_wdata", u_axi.m_wdata, 64'h0000_0000_00AB_0000);
    chk("t2_awaddr", u_axi.m_awaddr, 64'h8000_0020);
    step();
    u_axi.m_awready = 1'b0; u_axi.m_wready = 1'b0;
    chk("t2_valids_drop", {u_axi.m_awvalid, u_axi.m_wvalid}, 0);
    chk("t2_bready", u_axi.m_bready, 1);
    chk("t2_done_f2", u_tbus.tbus_operation_done, 0);
    u_axi.m_bvalid = 1'b1; u_axi.m_bresp = 2'b00;
    step();
    u_axi.m_bvalid = 1'b0;
    chk("t2_done_f3", u_tbus.tbus_operation_done, 1);
    chk("t2_berr", u_tbus.bus_error, 0);
    chk("t2_rdata_kept", u_tbus.tbus_read_data, D1);
    step();
    chk("t2_done_once", u_tbus.tbus_operation_done, 0);

    // 3: awready delayed, wready immediate
    req(TBUS_WRITE, 64'h8000_0040, D3, 64'hFFFF_FFFF_FFFF_FFFF);
    u_axi.m_wready = 1'b1;
    step();
    u_tbus.tbus_index_valid = 1'b0;
    chk("t3_c1_valids", {u_axi.m_awvalid, u_axi.m_wvalid}, 2'b11);
    chk("t3_wstrb", u_axi.m_wstrb, 8'hFF);
    step();
    u_axi.m_wready = 1'b0;
    chk("t3_c2_valids", {u_axi.m_awvalid, u_axi.m_wvalid}, 2'b10);
    step();
    chk("t3_c3_valids", {u_axi.m_awvalid, u_axi.m_wvalid}, 2'b10);
    u_axi.m_awready = 1'b1;
    step();
    u_axi.m_awready = 1'b0;
    chk("t3_c4_awdrop", u_axi.m_awvalid, 0);
    chk("t3_c4_bready", u_axi.m_bready, 1);
    chk("t3_c4_done", u_tbus.tbus_operation_done, 0);
    u_axi.m_bvalid = 1'b1;
    step();
    u_axi.m_bvalid = 1'b0;
    chk("t3_done", u_tbus.tbus_operation_done, 1);
    step();
    chk("t3_done_off", u_tbus.tbus_operation_done, 0);

    // 4+5: valid held across two reads; second returns SLVERR, address unaligned
    req(TBUS_READ, 64'h0000_0100, 0, 0);
    u_axi.m_arready = 1'b1;
    step();
    u_tbus.tbus_index = 64'h0000_020D;
    chk("t4_c1_ready", u_tbus.tbus_index_ready, 0);
    chk("t4_c1_araddr", u_axi.m_araddr, 64'h0000_0100);
    step();
    u_axi.m_rvalid = 1'b1; u_axi.m_rdata = D2; u_axi.m_rresp = 2'b00;
    chk("t4_c2_ready", u_tbus.tbus_index_ready, 0);
    step();
    u_axi.m_rvalid = 1'b0;
    chk("t4_c3_done", u_tbus.tbus_operation_done, 1);
    chk("t4_c3_ready", u_tbus.tbus_index_ready, 0);
    chk("t4_c3_rdata", u_tbus.tbus_read_data, D2);
    step();
    chk("t4_c4_ready", u_tbus.tbus_index_ready, 1);
    chk("t4_c4_arvalid", u_axi.m_arvalid, 0);
    step();
    u_tbus.tbus_index_valid = 1'b0;
    chk("t4_c5_arvalid", u_axi.m_arvalid, 1);
    chk("t4_c5_araddr_aligned", u_axi.m_araddr, 64'h0000_0208);
    step();
    u_axi.m_arready = 1'b0;
    u_axi.m_rvalid = 1'b1; u_axi.m_rdata = D3; u_axi.m_rresp = 2'b10;
    step();
    u_axi.m_rvalid = 1'b0; u_axi.m_rresp = 2'b00;
    chk("t5_done", u_tbus.tbus_operation_done, 1);
    chk("t5_berr", u_tbus.bus_error, 1);
    chk("t5_rdata", u_tbus.tbus_read_data, D3);
    step();
    chk("t5_pulse_end", {u_tbus.tbus_operation_done, u_tbus.bus_error}, 0);

    // Illegal operation type: immediate error response with zero data
    req(2'b11, 64'h0, 0, 0);
    step();
    u_tbus.tbus_index_valid = 1'b0;
    chk("ill_done", u_tbus.tbus_operation_done, 1);
    chk("ill_berr", u_tbus.bus_error, 1);
    chk("ill_rdata", u_tbus.tbus_read_data, 0);
    chk("ill_no_axi", {u_axi.m_arvalid, u_axi.m_awvalid, u_axi.m_wvalid}, 0);
    step();
    chk("ill_ready_back", u_tbus.tbus_index_ready, 1);

    // 6: reset in RD_D
    req(TBUS_READ, 64'h8000_0080, 0, 0);
    u_axi.m_arready = 1'b1;
    step();
    u_tbus.tbus_index_valid = 1'b0;
    step();
    u_axi.m_arready = 1'b0;
    chk("t6_in_rd_d", u_axi.m_rready, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_drop", {u_axi.m_arvalid, u_axi.m_rready, u_tbus.tbus_operation_done}, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("t6_ready", u_tbus.tbus_index_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_done", u_tbus.tbus_operation_done, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
